demux4_2_stage: RTL
===================

Name: demux4_2_stage

Overview:
- Registered 1-to-4 distribution stage for 16-bit datapath words; the inverse of the 4:1 source-select mux.
- Takes one word plus a 2-bit destination select and delivers it to one of four destination ports, or to all four in broadcast mode.
- Each destination has a 1-deep holding slot with a valid/ready handshake, so a stalled sink blocks only traffic addressed to it.
- Sits between the ALU/result bus and the write-back/forwarding consumers.

Parameters:
- WIDTH, 16, data width of DIN and O0..O3
- NDEST, 4, number of destination ports; fixed at 4, matching the 2-bit select

Ports:
- CLK  input  1  single system clock, rising edge
- RESET_N  input  1  asynchronous, active-low reset
- DIN  input  WIDTH  word to distribute
- S  input  2  destination select (0..3); ignored when BCAST=1
- BCAST  input  1  1 = deliver DIN to all four ports
- IN_VALID  input  1  sender has a word on DIN
- IN_READY  output  1  stage accepts the word this cycle
- O0..O3  output  WIDTH  per-destination data
- V0..V3  output  1  per-destination valid
- R0..R3  input  1  per-destination ready from sink
- BUSY  output  1  OR of V0..V3

Behaviour:
- Reset is asynchronous and active-low; it is already decided for this block. While RESET_N=0: V0..V3=0, O0..O3=0, BUSY=0. Any words held at reset assertion, including mid-handshake, are discarded with no partial delivery.
- Per slot k: can_take_k = !Vk | Rk.
- IN_READY (combinational):
  - BCAST=0: IN_READY = can_take[S].
  - BCAST=1: IN_READY = AND of can_take_0..3 (all-or-nothing).
- Combinational paths Rk->IN_READY and S/BCAST->IN_READY are intended and accepted.
- Accept occurs when IN_VALID & IN_READY. On the next edge:
  - Unicast: O[S] <= DIN, V[S] <= 1.
  - Broadcast: all Ok <= DIN, all Vk <= 1.
- Latency: accept edge to Vk=1 is 1 cycle. Throughput: 1 word per cycle per port when the sink holds Rk=1.
- Drain: when Vk & Rk and slot k is not loaded on this edge, Vk <= 0.
- Drain and load on the same edge: Vk stays 1 and Ok takes the new DIN, so there is no bubble.
- Ok holds its last value after Vk falls; sinks must qualify data with Vk.
- Rk is ignored while Vk=0.
- No accept when IN_VALID=0, whatever IN_READY shows.
- Sender rule: DIN, S and BCAST must stay stable while IN_VALID & !IN_READY. The stage does not check this.
- Broadcast is never partially delivered. If any slot is full and not draining, the whole word waits.
- BUSY = V0|V1|V2|V3, registered-derived with no combinational input path.

Decomposition:
- Shared package:
  - WIDTH = 16
  - NDEST = 4
  - select encoding constants DEST0..DEST3 = 2'd0..2'd3, shared with the 4:1 mux select users
- One sub-module, demux_slot:
  - Contents: one WIDTH-bit holding register, its valid flag, and the can_take output.
  - Inputs: load, din, rdy.
  - Instantiated four times.
  - The top level holds only the select decode, broadcast AND, and BUSY OR.

Test Plan:
- Reset: hold RESET_N=0 with random inputs -> V0..V3=0, O0..O3=0, BUSY=0. Assert RESET_N low asynchronously while V2=1 -> V2 drops at once, with no delivery after release.
- Unicast streaming: R2=1, send 0x1111, 0x2222, 0x3333 with S=2 on consecutive cycles -> IN_READY=1 each cycle, O2 shows each word 1 cycle after accept, V2 stays 1 across all three, V0/V1/V3=0.
- Backpressure isolation: R1=0, load 0xAAAA to port 1, then offer S=1 0xBBBB -> IN_READY=0 and O1 holds 0xAAAA. Switch S=3 with 0xCCCC -> accepted, O3=0xCCCC next cycle. Raise R1 -> 0xBBBB accepted in the same cycle, V1 stays high, O1=0xBBBB.
- Broadcast blocked: V0=1, R0=0, BCAST=1, DIN=0x5A5A -> IN_READY=0 and no slot changes. Raise R0 -> accept, and next cycle V0..V3=1, O0..O3=0x5A5A.
- Simultaneous drain and load: V3=1, R3=1, accept S=3 0x0F0F in the same cycle -> V3 stays 1, O3=0x0F0F; drop IN_VALID -> V3 falls the following cycle.
- Idle: IN_VALID=0 with IN_READY=1 for 10 cycles -> no Vk rises, BUSY=0.

Source files
------------

// File: rtl/demux4_2_stage_pkg.sv
// Shared constants for the 1-to-4 result distribution stage.
// Select encodings are common with the 4:1 source-select mux users.
package demux4_2_stage_pkg;

  localparam int WIDTH = 16;
  localparam int NDEST = 4;

  localparam logic [1:0] DEST0 = 2'd0;
  localparam logic [1:0] DEST1 = 2'd1;
  localparam logic [1:0] DEST2 = 2'd2;
  localparam logic [1:0] DEST3 = 2'd3;

endpackage

// File: rtl/demux_slot.sv
// One destination slot: 1-deep holding register with valid flag.
// A load on a draining edge keeps valid high, so there is no bubble.
module demux_slot
  import demux4_2_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             rdy,
  output logic [WIDTH-1:0] data,
  output logic             vld,
  output logic             can_take
);

  assign can_take = !vld || rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      vld  <= 1'b0;
    end else if (load) begin
      data <= din;
      vld  <= 1'b1;
    end else if (vld && rdy) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/demux4_2_stage.sv
// Registered 1-to-4 distribution stage with per-destination slots.
// Broadcast is all-or-nothing: it waits until every slot can take.
module demux4_2_stage
  import demux4_2_stage_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] DIN,
  input  logic [1:0]       S,
  input  logic             BCAST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic             V0,
  output logic             V1,
  output logic             V2,
  output logic             V3,
  input  logic             R0,
  input  logic             R1,
  input  logic             R2,
  input  logic             R3,
  output logic             BUSY
);

  logic [NDEST-1:0] sel;
  logic [NDEST-1:0] rdy;
  logic [NDEST-1:0] vld;
  logic [NDEST-1:0] can_take;
  logic [NDEST-1:0] load;
  logic [WIDTH-1:0] data [NDEST];
  logic             accept;

  always_comb begin
    sel = '0;
    unique case (S)
      DEST0: sel[0] = 1'b1;
      DEST1: sel[1] = 1'b1;
      DEST2: sel[2] = 1'b1;
      DEST3: sel[3] = 1'b1;
    endcase
  end

  assign rdy      = {R3, R2, R1, R0};
  assign IN_READY = BCAST ? &can_take : |(can_take & sel);
  assign accept   = IN_VALID && IN_READY;
  assign load     = {NDEST{accept}} & (sel | {NDEST{BCAST}});

  for (genvar k = 0; k < NDEST; k++) begin : g_slot
    demux_slot u_slot (
      .clk      (CLK),
      .rst_n    (RESET_N),
      .load     (load[k]),
      .din      (DIN),
      .rdy      (rdy[k]),
      .data     (data[k]),
      .vld      (vld[k]),
      .can_take (can_take[k])
    );
  end

  assign O0   = data[0];
  assign O1   = data[1];
  assign O2   = data[2];
  assign O3   = data[3];
  assign V0   = vld[0];
  assign V1   = vld[1];
  assign V2   = vld[2];
  assign V3   = vld[3];
  assign BUSY = |vld;

endmodule
